ssdisp_scan: RTL and testbench
==============================

SSDISP_SCAN -- requirements
Module: ssdisp_scan

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter DIV, default 1000: clock cycles each digit is shown, legal range 2..65535.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  one-cycle write strobe for a digit register.
REQ-006 SHALL have port wr_addr  input  3  digit index to write; writes with wr_addr >= NDIG are ignored.
REQ-007 SHALL have port wr_data  input  5  bit 4 = digit enable, bits 3:0 = hex value.
REQ-008 SHALL have port clr  input  1  synchronous clear of all digit registers.
REQ-009 SHALL have port ss_nib  output  4  value presented to the shared 7-segment decoder "in" input.
REQ-010 SHALL have port ss_en  output  1  drives the decoder "enable" input.
REQ-011 SHALL have port dig_sel  output  NDIG  one-hot digit common select; all zero while blanking.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse when a full scan of all digits completes.

Function
REQ-013 SHALL hold NDIG 5-bit digit registers {en, val}.
REQ-014 SHALL implement a state machine with states SHOW and BLANK, a digit index idx (0..NDIG-1) and a prescale counter pc.
REQ-015 In SHOW: dig_sel = one-hot(idx), ss_nib = val[idx], ss_en = en[idx]; pc counts 0..DIV-1, and at pc = DIV-1 the block SHALL move to BLANK with pc = 0.
REQ-016 In BLANK: dig_sel = 0, ss_en = 0, ss_nib = 0, lasting exactly 2 cycles; then SHOW with idx+1, wrapping NDIG-1 -> 0.
REQ-017 Per-digit period SHALL be DIV+2 cycles; frame period SHALL be NDIG*(DIV+2) cycles.
REQ-018 frame_tick SHALL be 1 for exactly the single cycle in which the state goes from BLANK to SHOW with idx wrapping to 0.
REQ-019 A write SHALL update the addressed register on the clock edge; if that digit is currently in SHOW, the new value SHALL appear on ss_nib/ss_en the following cycle with no change to timing.
REQ-020 clr SHALL set all en and val bits to 0 on the next edge; clr and wr_en in the same cycle -> clr wins, the write is discarded.
REQ-021 clr and writes SHALL NOT affect state, idx, pc or frame_tick.
REQ-022 Outputs SHALL be glitch-free functions of registered state only: no combinational path from any input to any output.

Reset
REQ-023 On n_rst low, immediately and regardless of clk: state = SHOW, idx = 0, pc = 0, all digit registers = 0, blink state = 0.
REQ-024 During and just after reset: dig_sel = one-hot(0), ss_nib = 0, ss_en = 0, frame_tick = 0.
REQ-025 Reset asserted mid-SHOW or mid-BLANK SHALL abandon the scan; the first cycle after release is SHOW with idx 0 and pc 0.

Configuration
REQ-026 With macro SSDISP_SCAN_BLINK_EN defined: SHALL add input port blink_mask (width NDIG) and a 5-bit frame counter that increments on frame_tick; blink phase = counter bit 4.
REQ-027 With SSDISP_SCAN_BLINK_EN defined: while blink phase = 1 and blink_mask[idx] = 1, SHOW SHALL force ss_en = 0 and dig_sel = 0; all timing is unchanged.
REQ-028 Without SSDISP_SCAN_BLINK_EN: no blink_mask port, no frame counter, no blanking beyond REQ-016.

Verification (NDIG=4, DIV=4 unless stated)
REQ-029 Release reset, no writes -> dig_sel 0001 for 4 cycles, 0000 for 2, 0010 for 4, ...; frame_tick once every 24 cycles; ss_en always 0.
REQ-030 Write addr 2 data 5'h1A, then wait -> during the idx=2 SHOW window ss_nib = 4'hA, ss_en = 1; other digits ss_en = 0.
REQ-031 Write addr 1 data 5'h17 in the 2nd cycle of idx=1 SHOW -> ss_nib = 7 from the 3rd cycle; the window still ends after cycle 4.
REQ-032 clr and wr_en (addr 0, 5'h13) in the same cycle after digits are loaded -> all digits read en = 0; write addr 5 -> no change anywhere.
REQ-033 Drop n_rst in the middle of BLANK for idx=3 -> outputs reach reset values without a clk edge; after release the scan restarts at idx 0 with a full 4-cycle window.
REQ-034 With SSDISP_SCAN_BLINK_EN defined: blink_mask = 0010, digit 1 enabled -> digit 1 is shown for frames 0-15 and blanked for frames 16-31, then repeats; other digits are unaffected.

Source files
------------

// File: rtl/ssdisp_scan.sv
// ssdisp_scan: time-multiplexed scanner for NDIG seven-segment digits.
// Each digit is shown for DIV cycles, followed by a 2-cycle blanking gap
// so that the outgoing digit's segments are dark before the next common
// is selected. Outputs are decoded purely from registered state.
// Optional feature: define SSDISP_SCAN_BLINK_EN to add a blink_mask input
// and a 5-bit frame counter; masked digits go dark for 16 of every 32 frames.
module ssdisp_scan #(
   parameter int NDIG = 8,
   parameter int DIV  = 1000
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            wr_en,
   input  logic [2:0]      wr_addr,
   input  logic [4:0]      wr_data,
   input  logic            clr,
`ifdef SSDISP_SCAN_BLINK_EN
   input  logic [NDIG-1:0] blink_mask,
`endif
   output logic [3:0]      ss_nib,
   output logic            ss_en,
   output logic [NDIG-1:0] dig_sel,
   output logic            frame_tick
);

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   localparam logic [15:0] PC_LAST   = 16'(DIV - 1);
   localparam logic [15:0] BLANK_END = 16'd1;
   localparam logic [2:0]  IDX_LAST  = 3'(NDIG - 1);

   state_t                state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [15:0]           pc_q, pc_d;
   logic [NDIG-1:0]       en_q, en_d;
   logic [NDIG-1:0][3:0]  val_q, val_d;
   logic                  blink_phase;

`ifdef SSDISP_SCAN_BLINK_EN
   logic [4:0]            frame_cnt_q, frame_cnt_d;

   // Frame counter advances once per completed scan; its MSB is the blink phase.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_tick) begin
         frame_cnt_d = frame_cnt_q + 5'd1;
      end
   end

   // Frame counter register, cleared only by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         frame_cnt_q <= 5'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign blink_phase = frame_cnt_q[4];
`else
   assign blink_phase = 1'b0;
`endif

   // Scan sequencer: SHOW for DIV cycles, BLANK for 2, then step to the next digit.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pc_d    = pc_q + 16'd1;
      case (state_q)
         SHOW: begin
            if (pc_q == PC_LAST) begin
               state_d = BLANK;
               pc_d    = 16'd0;
            end
         end
         BLANK: begin
            if (pc_q == BLANK_END) begin
               state_d = SHOW;
               pc_d    = 16'd0;
               idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end
         end
         default: begin
            state_d = SHOW;
            pc_d    = 16'd0;
            idx_d   = 3'd0;
         end
      endcase
   end

   // Digit register update: clear beats a same-cycle write; out-of-range addresses match no digit.
   always_comb begin
      en_d  = en_q;
      val_d = val_q;
      if (clr) begin
         en_d  = '0;
         val_d = '0;
      end else if (wr_en) begin
         for (int i = 0; i < NDIG; i++) begin
            if (wr_addr == 3'(i)) begin
               en_d[i]  = wr_data[4];
               val_d[i] = wr_data[3:0];
            end
         end
      end
   end

   // All state registers share the asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= SHOW;
         idx_q   <= 3'd0;
         pc_q    <= 16'd0;
         en_q    <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pc_q    <= pc_d;
         en_q    <= en_d;
         val_q   <= val_d;
      end
   end

   // Output decode from registered state only, so nothing glitches on input changes.
   always_comb begin
      ss_nib     = 4'd0;
      ss_en      = 1'b0;
      dig_sel    = '0;
      frame_tick = (state_q == BLANK) && (pc_q == BLANK_END) && (idx_q == IDX_LAST);
      if (state_q == SHOW) begin
         for (int i = 0; i < NDIG; i++) begin
            if (idx_q == 3'(i)) begin
               ss_nib = val_q[i];
`ifdef SSDISP_SCAN_BLINK_EN
               if (!(blink_phase && blink_mask[i])) begin
                  ss_en      = en_q[i];
                  dig_sel[i] = 1'b1;
               end
`else
               ss_en      = en_q[i] & ~blink_phase;
               dig_sel[i] = 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_ssdisp_scan.sv
// Scoreboard bench for ssdisp_scan (NDIG=4, DIV=4). The stimulus process
// pushes the expected outputs for every cycle; a monitor pops and compares
// on each falling edge.
module tb_ssdisp_scan;

   localparam int NDIG  = 4;
   localparam int DIV   = 4;
   localparam int PER   = DIV + 2;
   localparam int FRAME = NDIG * PER;

   logic            clk;
   logic            n_rst;
   logic            wr_en;
   logic [2:0]      wr_addr;
   logic [4:0]      wr_data;
   logic            clr;
   logic [3:0]      ss_nib;
   logic            ss_en;
   logic [NDIG-1:0] dig_sel;
   logic            frame_tick;
`ifdef SSDISP_SCAN_BLINK_EN
   logic [NDIG-1:0] blink_mask;
`endif

   typedef struct {
      logic [NDIG-1:0] sel;
      logic [3:0]      nib;
      logic            en;
      logic            ft;
      int              cyc;
      string           tag;
   } exp_t;

   exp_t       sbq[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         t = 0;
   string      tag = "reset";
   logic [4:0] shadow [NDIG];

   ssdisp_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clr        (clr),
`ifdef SSDISP_SCAN_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .ss_nib     (ss_nib),
      .ss_en      (ss_en),
      .dig_sel    (dig_sel),
      .frame_tick (frame_tick)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clearShadow();
      for (int i = 0; i < NDIG; i++) shadow[i] = 5'd0;
   endtask

   // Expected outputs for cycle t: digit d = (t/PER)%NDIG, position within its slot = t%PER.
   task automatic pushExpected(input bit inReset);
      exp_t e;
      int   pos;
      int   d;
      int   frame;
      logic [NDIG-1:0] one;
      one   = 1;
      e.sel = '0;
      e.nib = 4'd0;
      e.en  = 1'b0;
      e.ft  = 1'b0;
      e.cyc = t;
      e.tag = tag;
      if (inReset) begin
         e.sel = one;
      end else begin
         pos   = t % PER;
         d     = (t / PER) % NDIG;
         frame = (t / FRAME) % 32;
         if (pos < DIV) begin
            e.sel = one << d;
            e.nib = shadow[d][3:0];
            e.en  = shadow[d][4];
`ifdef SSDISP_SCAN_BLINK_EN
            if (frame >= 16 && blink_mask[d]) begin
               e.sel = '0;
               e.en  = 1'b0;
            end
`endif
         end
         e.ft = (pos == PER - 1) && (d == NDIG - 1);
         if (frame < 0) e.ft = 1'b0;
      end
      sbq.push_back(e);
   endtask

   // One normal cycle: record expectation, drive inputs, track register effect for later cycles.
   task automatic applyStimulus(input logic we, input logic [2:0] a, input logic [4:0] d,
                                input logic c);
      @(posedge clk);
      #1;
      pushExpected(1'b0);
      wr_en   = we;
      wr_addr = a;
      wr_data = d;
      clr     = c;
      if (c) clearShadow();
      else if (we && int'(a) < NDIG) shadow[a] = d;
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 5'd0, 1'b0);
   endtask

   // Idle until the next cycle is the given slot position of the given digit.
   task automatic advanceTo(input int pos, input int d);
      int guard;
      guard = 0;
      while (!((t % PER) == pos && ((t / PER) % NDIG) == d) && guard < 2 * FRAME) begin
         idle(1);
         guard++;
      end
      if (guard >= 2 * FRAME) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL advanceTo: slot pos %0d digit %0d not reached", pos, d);
      end
   endtask

   task automatic holdReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pushExpected(1'b1);
      end
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      t     = 0;
      pushExpected(1'b0);
      t     = 1;
   endtask

   // Drop reset between edges; the checked sample falls before the next rising edge.
   task automatic asyncReset();
      @(posedge clk);
      #2;
      n_rst   = 1'b0;
      wr_en   = 1'b0;
      clr     = 1'b0;
      clearShadow();
      pushExpected(1'b1);
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      if (dig_sel !== e.sel || ss_nib !== e.nib || ss_en !== e.en || frame_tick !== e.ft) begin
         miscompares++;
         $display("[TB] FAIL %s cyc %0d: got sel=%b nib=%h en=%b ft=%b, want sel=%b nib=%h en=%b ft=%b",
                  e.tag, e.cyc, dig_sel, ss_nib, ss_en, frame_tick, e.sel, e.nib, e.en, e.ft);
      end
   endtask

   // Monitor: compare one expectation per cycle, away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      n_rst   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 5'd0;
      clr     = 1'b0;
`ifdef SSDISP_SCAN_BLINK_EN
      blink_mask = 4'b0010;
`endif
      clearShadow();

      tag = "reset";
      holdReset(3);
      releaseReset();

      tag = "idle_scan";
      idle(2 * FRAME);

      tag = "write2";
      applyStimulus(1'b1, 3'd2, 5'h1A, 1'b0);
      idle(FRAME + 3);

      tag = "midwrite";
      advanceTo(1, 1);
      applyStimulus(1'b1, 3'd1, 5'h17, 1'b0);
      idle(FRAME);

      tag = "load";
      applyStimulus(1'b1, 3'd0, 5'h1C, 1'b0);
      applyStimulus(1'b1, 3'd3, 5'h15, 1'b0);
      idle(FRAME);

      tag = "clr_vs_wr";
      applyStimulus(1'b1, 3'd0, 5'h13, 1'b1);
      idle(FRAME);

      tag = "bad_addr";
      applyStimulus(1'b1, 3'd2, 5'h19, 1'b0);
      applyStimulus(1'b1, 3'd5, 5'h1F, 1'b0);
      applyStimulus(1'b1, 3'd7, 5'h1E, 1'b0);
      idle(FRAME);

      tag = "async_reset";
      advanceTo(PER - 1, 3);
      asyncReset();
      holdReset(2);
      releaseReset();
      tag = "after_reset";
      applyStimulus(1'b1, 3'd0, 5'h14, 1'b0);
      idle(FRAME + 2);

`ifdef SSDISP_SCAN_BLINK_EN
      tag = "blink";
      applyStimulus(1'b1, 3'd1, 5'h1B, 1'b0);
      idle(34 * FRAME);
`endif

      repeat (2) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d left, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
